// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back scheduler for the register file's single write port
// Ports:
//   Clock, Reset (async active-low)
//   Alu_Valid/Alu_Addr/Alu_Data -> Alu_Ready : ALU write-back request
//   Mem_Valid/Mem_Addr/Mem_Data -> Mem_Ready : load-return write-back request
//   Iss_Valid/Iss_Addr                        : load issue, marks destination busy
//   RAddr1/RAddr2 -> Stall                    : decode hazard check
//   Wen/WAddr/WData                           : registered register-file write port
// Optional: define WB_FAIRNESS_EN to force an ALU grant after MAX_WAIT losses.
module rf_wb_arbiter #(
    parameter int DSIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int NREG     = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Alu_Valid,
    input  logic [RSIZE-1:0] Alu_Addr,
    input  logic [DSIZE-1:0] Alu_Data,
    output logic             Alu_Ready,
    input  logic             Mem_Valid,
    input  logic [RSIZE-1:0] Mem_Addr,
    input  logic [DSIZE-1:0] Mem_Data,
    output logic             Mem_Ready,
    input  logic             Iss_Valid,
    input  logic [RSIZE-1:0] Iss_Addr,
    input  logic [RSIZE-1:0] RAddr1,
    input  logic [RSIZE-1:0] RAddr2,
    output logic             Stall,
    output logic             Wen,
    output logic [RSIZE-1:0] WAddr,
    output logic [DSIZE-1:0] WData
);
    logic [NREG-1:0] busy, busy_nxt;
    logic            alu_blk, force_alu;

`ifdef WB_FAIRNESS_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            wait_cnt <= '0;
        else if (Alu_Valid && !Alu_Ready)
            wait_cnt <= (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end
    assign force_alu = (wait_cnt == WW'(MAX_WAIT)) & Alu_Valid & ~alu_blk;
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_WAIT != 0);
    assign force_alu  = 1'b0;
`endif

    // An ALU write to a register with a pending load would race the load, so it waits.
    always_comb begin
        alu_blk   = busy[Alu_Addr];
        Alu_Ready = Alu_Valid & ~alu_blk & (~Mem_Valid | force_alu);
        Mem_Ready = Mem_Valid & ~force_alu;
        Stall     = busy[RAddr1] | busy[RAddr2] | (Iss_Valid & busy[Iss_Addr]) | (Alu_Valid & alu_blk);
    end

    // Clear first so a same-cycle issue to the returning address keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (Mem_Ready)
            busy_nxt[Mem_Addr] = 1'b0;
        if (Iss_Valid)
            busy_nxt[Iss_Addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy  <= '0;
            Wen   <= 1'b0;
            WAddr <= '0;
            WData <= '0;
        end else begin
            busy <= busy_nxt;
            Wen  <= Alu_Ready ? (Alu_Addr != '0) : Mem_Ready ? (Mem_Addr != '0) : 1'b0;
            if (Alu_Ready) begin
                WAddr <= Alu_Addr;
                WData <= Alu_Data;
            end else if (Mem_Ready) begin
                WAddr <= Mem_Addr;
                WData <= Mem_Data;
            end
        end
    end
endmodule
